rice_partition_optimizer: RTL and testbench
===========================================

Name: rice_partition_optimizer

Overview:
- Parametrised successor to the single-k Rice optimiser in the Stage 3 encode path.
- Consumes a stream of signed LPC residuals and zig-zag maps each one.
- Splits every block into 2^order equal partitions, with the order selectable at run time.
- For each partition, outputs the Rice parameter k (0..MAX_K) with the minimum exact coded bit count, plus that bit count.
- Next-partition accumulation overlaps current-partition selection.

Parameters:
- DATA_W, 16, residual width in bits (signed).
- BLOCK_SIZE, 4096, samples per block; power of two.
- MAX_K, 14, largest Rice parameter evaluated.
- MAX_PART_ORDER, 4, largest partition order accepted.
- Elaboration check: BLOCK_SIZE>>MAX_PART_ORDER ≥ MAX_K+2.

Ports:
- iClock, in, 1, clock; all state changes on the rising edge.
- iReset_n, in, 1, asynchronous active-low reset.
- iEnable, in, 1, when low, inputs are ignored and all state is frozen except the async reset.
- iValid, in, 1, iResidual is accepted on an edge where iValid && iEnable.
- iResidual, in, DATA_W, signed residual.
- iPartOrder, in, clog2(MAX_PART_ORDER+1), partition order; sampled on the first sample of each block.
- oValid, out, 1, one-cycle pulse; the result outputs are valid.
- oBestK, out, clog2(MAX_K+1), optimum k.
- oBits, out, COST_W, coded size of the partition excluding the partition header.
- oPartIndex, out, MAX_PART_ORDER, index of the partition within its block.
- oBlockDone, out, 1, high together with oValid for the last partition of a block.

Behaviour:
- Reset (async, iReset_n=0): every output is 0; counters, accumulators and the snapshot are cleared; FSM goes to IDLE.
- Zig-zag map: u = (r<<1) ^ (r>>>(DATA_W-1)), giving a DATA_W-bit unsigned value.
- Widths: ACC_W = DATA_W + clog2(BLOCK_SIZE); COST_W = ACC_W + 1. No overflow is possible, so no saturation logic.
- Accumulators: one per k. On each accepted sample, acc[k] += u>>k for k = 0..MAX_K.
- Order latch:
  - The order is latched when the sample counter equals 0.
  - If iPartOrder > MAX_PART_ORDER, the latched value is clamped to MAX_PART_ORDER.
  - Partition length n = BLOCK_SIZE >> order.
- Snapshot on the last sample of a partition:
  - The edge that accepts sample n-1 loads the snapshot with acc_next (which includes that sample) and the partition index.
  - The same edge clears the live accumulators, so the next sample starts a fresh partition with no lost cycle.
- FSM states:
  - IDLE: waits for the snapshot load, then goes to SELECT.
  - SELECT: one k per enabled cycle, for k = 0..MAX_K.
    - cost_k = n*(k+1) + snap[k].
    - Strict less-than compare, so ties keep the smaller k.
    - Running best k and cost are held in registers.
  - REPORT: drives oValid = 1 for one cycle, then returns to IDLE.
- Latency: oValid goes high MAX_K+2 enabled cycles after the edge that accepts the last sample of the partition.
- Throughput: one sample per cycle sustained. The elaboration check guarantees the snapshot is free before the next partition ends.
- oBestK, oBits, oPartIndex and oBlockDone hold their values after the oValid pulse until the next REPORT.
- Counters: the sample counter wraps at BLOCK_SIZE-1 to 0; the partition index wraps at the end of each block.
- iEnable low: mid-SELECT freezes the FSM; during REPORT it stretches oValid until the next enabled edge.
- iValid low: a gap in the stream; accumulation simply pauses.

Decomposition:
- Shared package: ACC_W and COST_W width functions, the zig-zag function, and the FSM state enum.
- One natural sub-module: rice_cost_accumulator_bank, holding the MAX_K+1 shifted-sum accumulators and the snapshot registers.

Test Plan (defaults unless noted):
- 4096 zero residuals, order 0 → one oValid: oBestK=0, oBits=4096, oPartIndex=0, oBlockDone=1.
- 4096 residuals of 100 (u=200), order 0 → k=7 and k=8 tie at 9 bits/sample; the smaller k is required: oBestK=7, oBits=36864.
- Order 2; partitions of 1024 × 0, 100, −1, 3 → four results: (k0, 1024), (k7, 9216), (k0, 2048, tie with k1 resolved to k0), (k2, 4096). oBlockDone only on the fourth result; consecutive oValid pulses are exactly 1024 cycles apart.
- 4096 residuals of −32768, order 0 → u=65535, best available k is MAX_K: oBestK=14, oBits=73728. No overflow.
- Boundary timing:
  - Back-to-back blocks with order 4 change to order 0 at the block boundary → partition lengths 256 then 4096.
  - oValid occurs exactly MAX_K+2 cycles after each last sample.
  - iPartOrder=7 is clamped to 4.
- Reset and gaps:
  - Deassert iReset_n mid-partition (sample 1000) → outputs are 0 immediately and no oValid follows. A fresh block afterwards gives the nominal results.
  - iEnable pulled low for 5 cycles during SELECT → oValid is delayed by exactly 5 cycles with unchanged values.

Source files
------------

// File: rtl/rice_partition_optimizer_pkg.sv
// Shared widths, zig-zag mapping and FSM state type for the partitioned Rice optimiser.
package rice_partition_optimizer_pkg;

  // Accumulator width: a whole block of full-scale zig-zag values cannot overflow it.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned block_size);
    return data_w + $clog2(block_size);
  endfunction

  // Cost width: one extra bit to hold the unary/stop-bit term on top of the shifted sum.
  function automatic int unsigned cost_width(input int unsigned data_w,
                                             input int unsigned block_size);
    return acc_width(data_w, block_size) + 1;
  endfunction

  // Zig-zag map on a sign-extended residual; caller truncates to its own width.
  function automatic logic [63:0] zigzag64(input logic [63:0] r);
    return (r << 1) ^ {64{r[63]}};
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/rice_cost_accumulator_bank.sv
// Per-k shifted-sum accumulators plus the end-of-partition snapshot.
//   clk_i, rst_ni : clock, async active-low reset
//   accept_i      : a residual is accepted this edge
//   last_i        : the accepted residual closes its partition
//   u_i           : zig-zag mapped residual
//   sel_k_i       : k whose snapshot sum is presented on snap_sel_o
//   snap_sel_o    : snapshot of sum(u >> sel_k_i) over the last closed partition
module rice_cost_accumulator_bank
  import rice_partition_optimizer_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BLOCK_SIZE = 4096,
  parameter int unsigned MAX_K      = 14
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  accept_i,
  input  logic                                  last_i,
  input  logic [DATA_W-1:0]                     u_i,
  input  logic [$clog2(MAX_K+1)-1:0]            sel_k_i,
  output logic [acc_width(DATA_W, BLOCK_SIZE)-1:0] snap_sel_o
);

  localparam int unsigned ACC_W = acc_width(DATA_W, BLOCK_SIZE);
  localparam int unsigned NK    = MAX_K + 1;

  logic [ACC_W-1:0] acc_q    [NK];
  logic [ACC_W-1:0] acc_next [NK];
  logic [ACC_W-1:0] snap_q   [NK];

  // Sum including the sample being accepted this edge.
  always_comb begin
    for (int k = 0; k < int'(NK); k++) begin
      acc_next[k] = acc_q[k] + ACC_W'(u_i >> k);
    end
  end

  // The closing sample lands in the snapshot and the live sums restart at zero on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NK); k++) begin
        acc_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else if (accept_i) begin
      for (int k = 0; k < int'(NK); k++) begin
        if (last_i) begin
          snap_q[k] <= acc_next[k];
          acc_q[k]  <= '0;
        end else begin
          acc_q[k]  <= acc_next[k];
        end
      end
    end
  end

  assign snap_sel_o = snap_q[sel_k_i];

endmodule

// File: rtl/rice_partition_optimizer.sv
// Partitioned Rice parameter optimiser: picks the minimum-cost k per partition.
//   iClock, iReset_n : clock, async active-low reset
//   iEnable          : global clock enable; low freezes all state
//   iValid/iResidual : signed residual stream
//   iPartOrder       : partition order, sampled on the first sample of each block
//   oValid           : result pulse; oBestK/oBits/oPartIndex/oBlockDone hold until the next one
module rice_partition_optimizer
  import rice_partition_optimizer_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned BLOCK_SIZE     = 4096,
  parameter int unsigned MAX_K          = 14,
  parameter int unsigned MAX_PART_ORDER = 4
) (
  input  logic                                     iClock,
  input  logic                                     iReset_n,
  input  logic                                     iEnable,
  input  logic                                     iValid,
  input  logic signed [DATA_W-1:0]                 iResidual,
  input  logic [$clog2(MAX_PART_ORDER+1)-1:0]      iPartOrder,
  output logic                                     oValid,
  output logic [$clog2(MAX_K+1)-1:0]               oBestK,
  output logic [cost_width(DATA_W, BLOCK_SIZE)-1:0] oBits,
  output logic [MAX_PART_ORDER-1:0]                oPartIndex,
  output logic                                     oBlockDone
);

  localparam int unsigned ACC_W  = acc_width(DATA_W, BLOCK_SIZE);
  localparam int unsigned COST_W = cost_width(DATA_W, BLOCK_SIZE);
  localparam int unsigned CNT_W  = $clog2(BLOCK_SIZE);
  localparam int unsigned KW     = $clog2(MAX_K + 1);
  localparam int unsigned OW     = $clog2(MAX_PART_ORDER + 1);
  localparam int unsigned PW     = MAX_PART_ORDER;

  // The shortest partition must outlast one full selection pass.
  if ((BLOCK_SIZE >> MAX_PART_ORDER) < MAX_K + 2) begin : g_param_check
    $error("BLOCK_SIZE>>MAX_PART_ORDER must be at least MAX_K+2");
  end

  // Input-side signals
  logic              accept;
  logic [DATA_W-1:0] u_zz;
  logic [OW-1:0]     ord_in;
  logic [OW-1:0]     ord_eff;
  logic [CNT_W-1:0]  part_mask;
  logic              part_last;
  logic              block_last;
  logic [PW-1:0]     part_idx;

  // Sample counter, latched order and snapshot metadata
  logic [CNT_W-1:0]  cnt_q;
  logic [OW-1:0]     ord_q;
  logic [PW-1:0]     snap_pidx_q;
  logic              snap_bdone_q;
  logic [OW-1:0]     snap_ord_q;
  logic [ACC_W-1:0]  snap_sel;

  // Selection FSM and registered outputs
  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     best_k_q, best_k_d;
  logic [COST_W-1:0] best_cost_q, best_cost_d;
  logic [COST_W-1:0] cost_c;
  logic              valid_q, valid_d;
  logic [KW-1:0]     out_k_q, out_k_d;
  logic [COST_W-1:0] out_bits_q, out_bits_d;
  logic [PW-1:0]     out_pidx_q, out_pidx_d;
  logic              out_bdone_q, out_bdone_d;

  assign accept = iEnable && iValid;
  assign u_zz   = DATA_W'(zigzag64(64'(iResidual)));

  // The first sample of a block uses the fresh order so its partition math is consistent.
  assign ord_in     = (iPartOrder > OW'(MAX_PART_ORDER)) ? OW'(MAX_PART_ORDER) : iPartOrder;
  assign ord_eff    = (cnt_q == '0) ? ord_in : ord_q;
  assign part_mask  = CNT_W'((BLOCK_SIZE >> ord_eff) - 1);
  assign part_last  = accept && ((cnt_q & part_mask) == part_mask);
  assign block_last = (cnt_q == CNT_W'(BLOCK_SIZE - 1));
  assign part_idx   = PW'(cnt_q >> (CNT_W - 32'(ord_eff)));

  rice_cost_accumulator_bank #(
    .DATA_W     (DATA_W),
    .BLOCK_SIZE (BLOCK_SIZE),
    .MAX_K      (MAX_K)
  ) u_bank (
    .clk_i      (iClock),
    .rst_ni     (iReset_n),
    .accept_i   (accept),
    .last_i     (part_last),
    .u_i        (u_zz),
    .sel_k_i    (k_q),
    .snap_sel_o (snap_sel)
  );

  // Stream bookkeeping: counter wraps naturally at the power-of-two block size.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q        <= '0;
      ord_q        <= '0;
      snap_pidx_q  <= '0;
      snap_bdone_q <= 1'b0;
      snap_ord_q   <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == '0) begin
        ord_q <= ord_in;
      end
      if (part_last) begin
        snap_pidx_q  <= part_idx;
        snap_bdone_q <= block_last;
        snap_ord_q   <= ord_eff;
      end
    end
  end

  // cost_k = n*(k+1) + sum(u>>k), with n a power of two.
  assign cost_c = ((COST_W'(k_q) + COST_W'(1)) << (CNT_W - 32'(snap_ord_q)))
                  + COST_W'(snap_sel);

  // Next-state and output logic; a snapshot arriving during REPORT chains straight into SELECT.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    best_k_d    = best_k_q;
    best_cost_d = best_cost_q;
    valid_d     = 1'b0;
    out_k_d     = out_k_q;
    out_bits_d  = out_bits_q;
    out_pidx_d  = out_pidx_q;
    out_bdone_d = out_bdone_q;
    case (state_q)
      ST_IDLE: begin
        if (part_last) begin
          state_d = ST_SELECT;
          k_d     = '0;
        end
      end
      ST_SELECT: begin
        if ((k_q == '0) || (cost_c < best_cost_q)) begin
          best_k_d    = k_q;
          best_cost_d = cost_c;
        end
        if (k_q == KW'(MAX_K)) begin
          state_d = ST_REPORT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_REPORT: begin
        valid_d     = 1'b1;
        out_k_d     = best_k_q;
        out_bits_d  = best_cost_q;
        out_pidx_d  = snap_pidx_q;
        out_bdone_d = snap_bdone_q;
        if (part_last) begin
          state_d = ST_SELECT;
          k_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers; iEnable low freezes everything, stretching oValid.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      best_k_q    <= '0;
      best_cost_q <= '0;
      valid_q     <= 1'b0;
      out_k_q     <= '0;
      out_bits_q  <= '0;
      out_pidx_q  <= '0;
      out_bdone_q <= 1'b0;
    end else if (iEnable) begin
      state_q     <= state_d;
      k_q         <= k_d;
      best_k_q    <= best_k_d;
      best_cost_q <= best_cost_d;
      valid_q     <= valid_d;
      out_k_q     <= out_k_d;
      out_bits_q  <= out_bits_d;
      out_pidx_q  <= out_pidx_d;
      out_bdone_q <= out_bdone_d;
    end
  end

  assign oValid     = valid_q;
  assign oBestK     = out_k_q;
  assign oBits      = out_bits_q;
  assign oPartIndex = out_pidx_q;
  assign oBlockDone = out_bdone_q;

endmodule

// File: tb/tb_rice_partition_optimizer.sv
// Self-checking bench for rice_partition_optimizer against a direct cost-search model.
module tb_rice_partition_optimizer;

  localparam int BLOCK_SIZE = 4096;
  localparam int MAX_K      = 14;
  localparam int MAX_ORD    = 4;
  localparam int LAT        = MAX_K + 2;

  logic               iClock     = 1'b0;
  logic               iReset_n   = 1'b0;
  logic               iEnable    = 1'b0;
  logic               iValid     = 1'b0;
  logic signed [15:0] iResidual  = '0;
  logic [2:0]         iPartOrder = '0;
  logic               oValid;
  logic [3:0]         oBestK;
  logic [28:0]        oBits;
  logic [3:0]         oPartIndex;
  logic               oBlockDone;

  typedef struct {
    int     k;
    longint bits;
    int     pidx;
    int     bdone;
    longint cyc;
  } ev_t;

  ev_t    obs_q[$];
  ev_t    exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     res  [BLOCK_SIZE];
  int     pbuf [BLOCK_SIZE];
  logic   prev_v   = 1'b0;

  rice_partition_optimizer dut (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .iEnable    (iEnable),
    .iValid     (iValid),
    .iResidual  (iResidual),
    .iPartOrder (iPartOrder),
    .oValid     (oValid),
    .oBestK     (oBestK),
    .oBits      (oBits),
    .oPartIndex (oPartIndex),
    .oBlockDone (oBlockDone)
  );

  always #5 iClock = ~iClock;
  always @(posedge iClock) cyc <= cyc + 1;

  // Capture each result pulse with the edge count at which it appeared.
  always @(negedge iClock) begin : mon
    ev_t e;
    if (iReset_n && oValid && !prev_v) begin
      e.k     = int'(oBestK);
      e.bits  = longint'(oBits);
      e.pidx  = int'(oPartIndex);
      e.bdone = int'(oBlockDone);
      e.cyc   = cyc;
      obs_q.push_back(e);
    end
    prev_v = oValid;
  end

  function automatic int zz(input int r);
    return (r >= 0) ? 2 * r : -2 * r - 1;
  endfunction

  // Exhaustive search over k of the exact Rice-coded size of pbuf[0..n-1].
  task automatic model_partition(input int n, input int pidx, input int bdone, input longint edge_cyc);
    ev_t    e;
    longint best;
    longint c;
    int     bk;
    best = -1;
    bk   = 0;
    for (int k = 0; k <= MAX_K; k++) begin
      c = longint'(n) * (k + 1);
      for (int i = 0; i < n; i++) c += longint'(pbuf[i] >> k);
      if (best < 0 || c < best) begin
        best = c;
        bk   = k;
      end
    end
    e.k = bk; e.bits = best; e.pidx = pidx; e.bdone = bdone; e.cyc = edge_cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic fill_random();
    int s, r;
    s = int'($urandom_range(14));
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      r = int'($urandom_range(2 << s)) - (1 << s);
      if ($urandom_range(63) == 0) r = -32768;
      res[i] = r;
    end
  endtask

  // Stream res[] as one block, optionally with iValid gaps, and queue model expectations.
  task automatic play_block(input int order_req, input int gap_pct);
    int ord, n;
    ord = (order_req > MAX_ORD) ? MAX_ORD : order_req;
    n   = BLOCK_SIZE >> ord;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        iValid = 1'b0; iResidual = 16'($urandom); iPartOrder = 3'($urandom);
        @(posedge iClock); #1;
      end
      iValid     = 1'b1;
      iResidual  = 16'(res[i]);
      iPartOrder = (i == 0) ? 3'(order_req) : 3'($urandom);
      @(posedge iClock); #1;
      pbuf[i % n] = zz(res[i]);
      if (i % n == n - 1) model_partition(n, i / n, (i == BLOCK_SIZE - 1) ? 1 : 0, cyc);
    end
    iValid = 1'b0;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0; iEnable = 1'b0;
    repeat (3) @(posedge iClock);
    #1;
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d need 0", oValid); end
    n_checks++; if (oBestK !== 4'd0) begin n_fail++; $display("FAIL reset_bestk got %0d need 0", oBestK); end
    n_checks++; if (oBits !== 29'd0) begin n_fail++; $display("FAIL reset_bits got %0d need 0", oBits); end
    n_checks++; if (oPartIndex !== 4'd0) begin n_fail++; $display("FAIL reset_part got %0d need 0", oPartIndex); end
    n_checks++; if (oBlockDone !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0d need 0", oBlockDone); end
    @(negedge iClock);
    iReset_n = 1'b1; iEnable = 1'b1;
    @(posedge iClock); #1;
  endtask

  // Directed blocks: zeros, constant 100, full-scale negative, mixed order-2 block.
  task automatic test_patterns();
    int tk[7];
    int tb[7];
    int ts[4];
    int tn[4];
    tk = '{0, 7, 14, 0, 7, 0, 2};
    tb = '{4096, 36864, 73728, 1024, 9216, 2048, 4096};
    ts = '{0, 1, 2, 3};
    tn = '{1, 1, 1, 4};
    for (int p = 0; p < 4; p++) begin
      obs_q.delete(); exp_q.delete();
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        case (p)
          0: res[i] = 0;
          1: res[i] = 100;
          2: res[i] = -32768;
          default: res[i] = (i < 1024) ? 0 : (i < 2048) ? 100 : (i < 3072) ? -1 : 3;
        endcase
      end
      play_block((p == 3) ? 2 : 0, 0);
      repeat (LAT + 8) @(posedge iClock);
      #1;
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL pattern%0d_count got %0d need %0d", p, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].k !== exp_q[i].k || obs_q[i].bits !== exp_q[i].bits || obs_q[i].pidx !== exp_q[i].pidx
            || obs_q[i].bdone !== exp_q[i].bdone || obs_q[i].cyc !== exp_q[i].cyc) begin
          n_fail++;
          $display("FAIL pattern%0d_ev%0d got k=%0d bits=%0d part=%0d done=%0d cyc=%0d need k=%0d bits=%0d part=%0d done=%0d cyc=%0d",
                   p, i, obs_q[i].k, obs_q[i].bits, obs_q[i].pidx, obs_q[i].bdone, obs_q[i].cyc,
                   exp_q[i].k, exp_q[i].bits, exp_q[i].pidx, exp_q[i].bdone, exp_q[i].cyc);
        end
      end
      for (int j = 0; j < tn[p]; j++) begin
        n_checks++;
        if (j >= obs_q.size()) begin
          n_fail++; $display("FAIL pattern%0d_known%0d got no result need k=%0d bits=%0d", p, j, tk[ts[p]+j], tb[ts[p]+j]);
        end else if (obs_q[j].k !== tk[ts[p]+j] || obs_q[j].bits !== longint'(tb[ts[p]+j])) begin
          n_fail++;
          $display("FAIL pattern%0d_known%0d got k=%0d bits=%0d need k=%0d bits=%0d",
                   p, j, obs_q[j].k, obs_q[j].bits, tk[ts[p]+j], tb[ts[p]+j]);
        end
      end
    end
  endtask

  // Random blocks back to back with order changes at block boundaries, clamping and gaps.
  task automatic test_back_to_back();
    int orders[5];
    int gaps[5];
    orders = '{4, 0, 7, 2, 3};
    gaps   = '{0, 0, 20, 20, 20};
    obs_q.delete(); exp_q.delete();
    for (int b = 0; b < 5; b++) begin
      fill_random();
      play_block(orders[b], gaps[b]);
    end
    repeat (LAT + 8) @(posedge iClock);
    #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d need %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].k !== exp_q[i].k || obs_q[i].bits !== exp_q[i].bits || obs_q[i].pidx !== exp_q[i].pidx
          || obs_q[i].bdone !== exp_q[i].bdone || obs_q[i].cyc !== exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL b2b_ev%0d got k=%0d bits=%0d part=%0d done=%0d cyc=%0d need k=%0d bits=%0d part=%0d done=%0d cyc=%0d",
                 i, obs_q[i].k, obs_q[i].bits, obs_q[i].pidx, obs_q[i].bdone, obs_q[i].cyc,
                 exp_q[i].k, exp_q[i].bits, exp_q[i].pidx, exp_q[i].bdone, exp_q[i].cyc);
      end
    end
  endtask

  // iEnable low for 5 edges during SELECT must delay the result by exactly 5 edges.
  task automatic test_enable_stall();
    obs_q.delete(); exp_q.delete();
    fill_random();
    play_block(0, 0);
    repeat (3) @(posedge iClock);
    #1;
    iEnable = 1'b0;
    repeat (5) @(posedge iClock);
    #1;
    iEnable = 1'b1;
    repeat (LAT + 10) @(posedge iClock);
    #1;
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL stall_count got %0d need 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].k !== exp_q[0].k || obs_q[0].bits !== exp_q[0].bits || obs_q[0].bdone !== 1) begin
        n_fail++;
        $display("FAIL stall_value got k=%0d bits=%0d done=%0d need k=%0d bits=%0d done=1",
                 obs_q[0].k, obs_q[0].bits, obs_q[0].bdone, exp_q[0].k, exp_q[0].bits);
      end
      n_checks++;
      if (obs_q[0].cyc !== exp_q[0].cyc + 5) begin
        n_fail++; $display("FAIL stall_timing got cyc=%0d need cyc=%0d", obs_q[0].cyc, exp_q[0].cyc + 5);
      end
    end
  endtask

  // Reset in the middle of a block, then a fresh block must give nominal results.
  task automatic test_reset_mid();
    fill_random();
    for (int i = 0; i < 1000; i++) begin
      iValid     = 1'b1;
      iResidual  = 16'(res[i]);
      iPartOrder = (i == 0) ? 3'd4 : 3'($urandom);
      @(posedge iClock); #1;
    end
    iValid = 1'b0;
    obs_q.delete(); exp_q.delete();
    iReset_n = 1'b0;
    #1;
    n_checks++;
    if (oBits !== 29'd0 || oBestK !== 4'd0) begin
      n_fail++; $display("FAIL midreset_result got k=%0d bits=%0d need 0 0", oBestK, oBits);
    end
    n_checks++;
    if (oValid !== 1'b0 || oPartIndex !== 4'd0 || oBlockDone !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags got v=%0d part=%0d done=%0d need 0 0 0", oValid, oPartIndex, oBlockDone);
    end
    @(negedge iClock);
    iReset_n = 1'b1;
    repeat (LAT + 10) @(posedge iClock);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_spurious got %0d results need 0", obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
    fill_random();
    play_block(2, 10);
    repeat (LAT + 8) @(posedge iClock);
    #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL postreset_count got %0d need %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].k !== exp_q[i].k || obs_q[i].bits !== exp_q[i].bits || obs_q[i].pidx !== exp_q[i].pidx
          || obs_q[i].bdone !== exp_q[i].bdone || obs_q[i].cyc !== exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL postreset_ev%0d got k=%0d bits=%0d part=%0d done=%0d cyc=%0d need k=%0d bits=%0d part=%0d done=%0d cyc=%0d",
                 i, obs_q[i].k, obs_q[i].bits, obs_q[i].pidx, obs_q[i].bdone, obs_q[i].cyc,
                 exp_q[i].k, exp_q[i].bits, exp_q[i].pidx, exp_q[i].bdone, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_enable_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
